// File: rtl/soc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_pkg                                                              |
// | Shared SOC constants and the DMEM slave state encoding.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package soc_pkg;

  localparam logic [31:0] DMEM_BASE      = 32'h1000_0000;
  localparam logic [31:0] DMEM_STACK_TOP = 32'h1000_8000;
  localparam int          NBE            = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/soc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_if                                                               |
// | Fabric-to-slave vld/rdy bus with byte write strobes.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface soc_if;
  import soc_pkg::*;

  logic           vld;
  logic [31:0]    addr;
  logic [NBE-1:0] we;
  logic [31:0]    wdat;
  logic           rdy;
  logic [31:0]    rdat;

  modport MST (output vld, addr, we, wdat, input  rdy, rdat);
  modport SLV (input  vld, addr, we, wdat, output rdy, rdat);

endinterface
`default_nettype wire

// File: rtl/soc_bram_sp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_bram_sp                                                          |
// | Inferred single-port RAM, byte write enables, 1- or 2-cycle read.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module soc_bram_sp
  import soc_pkg::*;
#(
  parameter int    DEPTH_WORDS = 8192,
  parameter int    AW          = 13,
  parameter int    RD_LAT      = 1,
  parameter string INIT_FILE   = ""
) (
  input  wire logic           clk,
  input  wire logic           en,
  input  wire logic [NBE-1:0] we,
  input  wire logic [AW-1:0]  addr,
  input  wire logic [31:0]    wdat,
  output logic      [31:0]    rdat
);

  logic [31:0] mem [0:DEPTH_WORDS-1];
  logic [31:0] q_raw;

  // Read port only updates on a pure read so q_raw holds between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NBE; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
      if (we == '0) begin
        q_raw <= mem[addr];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_out_reg
      logic [31:0] q_reg;
      always_ff @(posedge clk) begin
        q_reg <= q_raw;
      end
      assign rdat = q_reg;
    end else if (RD_LAT == 1) begin : g_out_raw
      assign rdat = q_raw;
    end else begin : g_bad_rd_lat
      $error("soc_bram_sp: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/soc_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_dmem                                                             |
// | DMEM slave: vld/rdy handshake FSM in front of a byte-write BRAM.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module soc_dmem
  import soc_pkg::*;
#(
  parameter int    DEPTH_WORDS = 8192,
  parameter int    RD_LAT      = 1,
  parameter string INIT_FILE   = ""
) (
  input  wire logic clk,
  input  wire logic rst,
  soc_if.SLV        bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  generate
    if ((1 << AW) != DEPTH_WORDS) begin : g_bad_depth
      $error("soc_dmem: DEPTH_WORDS must be a power of 2");
    end
  endgenerate

  dmem_state_t state, state_nxt;
  logic        accept;
  logic        is_rd;
  logic [31:0] rdat_hold;
  logic [31:0] ram_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  soc_bram_sp #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .RD_LAT      (RD_LAT),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (accept),
    .we   (bus.we),
    .addr (bus.addr[AW+1:2]),
    .wdat (bus.wdat),
    .rdat (ram_q)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.vld) begin
          accept = 1'b1;
          if (bus.we != '0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = (RD_LAT == 2) ? RD_WAIT : RESP;
          end
        end
      end
      RD_WAIT: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_rd     <= 1'b0;
      rdat_hold <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_rd <= (bus.we == '0);
      end
      if (state == RESP && is_rd) begin
        rdat_hold <= ram_q;
      end
    end
  end

  // The RAM output is presented directly in the response cycle and then
  // held, so a write response leaves the last read data untouched.
  assign bus.rdy  = (state == RESP);
  assign bus.rdat = (state == RESP && is_rd) ? ram_q : rdat_hold;

endmodule
`default_nettype wire

// File: tb/tb_soc_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_soc_dmem                                                          |
// | Directed bench for soc_dmem with RD_LAT=1 (dut1) and RD_LAT=2 (dut2).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_soc_dmem;
  import soc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  soc_if bus1 ();
  soc_if bus2 ();

  soc_dmem #(.DEPTH_WORDS(8192), .RD_LAT(1), .INIT_FILE("")) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  soc_dmem #(.DEPTH_WORDS(8192), .RD_LAT(2), .INIT_FILE("")) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 1) begin
      bus1.vld = v; bus1.we = we; bus1.addr = a; bus1.wdat = w;
    end else begin
      bus2.vld = v; bus2.we = we; bus2.addr = a; bus2.wdat = w;
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 1) ? bus1.rdy : bus2.rdy;
  endfunction

  function automatic logic [31:0] get_rdat(input int d);
    return (d == 1) ? bus1.rdat : bus2.rdat;
  endfunction

  // Starts in an IDLE cycle; garbles the request after accept, returns in IDLE.
  task automatic txn(input int d, input logic [3:0] we, input logic [31:0] a,
                     input logic [31:0] w, output logic [31:0] rd, output int lat);
    drive(d, 1'b1, we, a, w);
    @(posedge clk); #1;
    drive(d, 1'b1, we, ~a, ~w);
    lat = 1;
    while (!get_rdy(d) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = get_rdat(d);
    drive(d, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rdy_single_pulse", {31'h0, get_rdy(d)}, 32'h0);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        exp_rdy;

  initial begin
    tbl[0] = '{4'hF, 32'h1000_0010, 32'h1122_3344, 32'hDEAD_BEEF};
    tbl[1] = '{4'h5, 32'h1000_0010, 32'hAAAA_AAAA, 32'hDEAD_BEEF};
    tbl[2] = '{4'h0, 32'h1000_0010, 32'h0000_0000, 32'h11AA_33AA};
    tbl[3] = '{4'hF, 32'h1000_0004, 32'h5A5A_5A5A, 32'h11AA_33AA};
    tbl[4] = '{4'h0, 32'h1000_8004, 32'h0000_0000, 32'h5A5A_5A5A};
    tbl[5] = '{4'h0, 32'h1000_0007, 32'h0000_0000, 32'h5A5A_5A5A};
    tbl[6] = '{4'h8, 32'h1000_0010, 32'hFF00_0000, 32'h5A5A_5A5A};
    tbl[7] = '{4'h0, 32'h1000_0010, 32'h0000_0000, 32'hFFAA_33AA};
    tbl[8] = '{4'h2, 32'h1000_0004, 32'h0000_BB00, 32'hFFAA_33AA};
    tbl[9] = '{4'h0, 32'h1000_0004, 32'h0000_0000, 32'h5A5A_BB5A};

    rst = 1'b1;
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset_rdy1", {31'h0, bus1.rdy}, 32'h0);
      chk("reset_rdat1", bus1.rdat, 32'h0);
      chk("reset_rdy2", {31'h0, bus2.rdy}, 32'h0);
    end
    rst = 1'b0;

    // Preload word 0, read it, then prove reset clears rdat but not memory.
    txn(1, 4'hF, DMEM_BASE, 32'hDEAD_BEEF, rd, lat);
    chk("wr0_lat", lat, 1);
    txn(1, 4'h0, DMEM_BASE, 32'h0, rd, lat);
    chk("rd0_rdat", rd, 32'hDEAD_BEEF);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst2_rdy", {31'h0, bus1.rdy}, 32'h0);
      chk("rst2_rdat", bus1.rdat, 32'h0);
    end
    rst = 1'b0;
    txn(1, 4'h0, DMEM_BASE, 32'h0, rd, lat);
    chk("rd0_after_rst_lat", lat, 1);
    chk("rd0_after_rst_rdat", rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 10; i++) begin
      txn(1, tbl[i].we, tbl[i].addr, tbl[i].wdat, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_rdat", i), rd, tbl[i].exp_rdat);
    end

    // vld held across four reads: rdy on every other cycle only.
    drive(1, 1'b1, 4'h0, 32'h1000_0010, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      exp_rdy = (c % 2 == 1) && (c <= 7);
      chk($sformatf("b2b_rdy_c%0d", c), {31'h0, bus1.rdy}, {31'h0, exp_rdy});
      if (exp_rdy) chk($sformatf("b2b_rdat_c%0d", c), bus1.rdat, 32'hFFAA_33AA);
      if (c == 7) drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    end

    txn(2, 4'hF, 32'h1000_000C, 32'hCAFE_F00D, rd, lat);
    chk("l2_wr_lat", lat, 1);
    txn(2, 4'h0, 32'h1000_000C, 32'h0, rd, lat);
    chk("l2_rd_lat", lat, 2);
    chk("l2_rd_rdat", rd, 32'hCAFE_F00D);

    // Reset during RD_WAIT drops the response; committed write survives.
    txn(2, 4'hF, 32'h1000_0014, 32'h0BAD_CAFE, rd, lat);
    chk("l2_wr5_lat", lat, 1);
    drive(2, 1'b1, 4'h0, 32'h1000_0014, 32'h0);
    @(posedge clk); #1;
    chk("midrd_wait_rdy", {31'h0, bus2.rdy}, 32'h0);
    rst = 1'b1;
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("midrd_rst_rdy", {31'h0, bus2.rdy}, 32'h0);
    chk("midrd_rst_rdat", bus2.rdat, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrd_no_late_rdy", {31'h0, bus2.rdy}, 32'h0);
    end
    txn(2, 4'h0, 32'h1000_0014, 32'h0, rd, lat);
    chk("post_rst_rd_lat", lat, 2);
    chk("post_rst_rd_rdat", rd, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
